// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and constants for the stopwatch lap controller
package stopwatch_pkg;

    localparam int BCD_W  = 4;
    localparam int LAP_DW = 4 * BCD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/stopwatch_lap_ctrl_if.sv
// rtl/stopwatch_lap_ctrl_if.sv - command, timer, lap-read and status bundle
interface stopwatch_lap_ctrl_if #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          cmd_start;
    logic          cmd_pause;
    logic          cmd_lap;
    logic          cmd_clear;
    logic [DW-1:0] time_bcd;
    logic          run_en;
    logic          timer_clr;
    logic          rd_req;
    logic [AW-1:0] rd_idx;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic [AW:0]   lap_count;
    logic          full;
    logic          ovf;

    modport master (
        output cmd_start, cmd_pause, cmd_lap, cmd_clear, time_bcd, rd_req, rd_idx,
        input  run_en, timer_clr, rd_ack, rd_data, lap_count, full, ovf
    );

    modport slave (
        input  cmd_start, cmd_pause, cmd_lap, cmd_clear, time_bcd, rd_req, rd_idx,
        output run_en, timer_clr, rd_ack, rd_data, lap_count, full, ovf
    );

endinterface

// File: rtl/stopwatch_lap_ctrl_lap_ram.sv
// rtl/stopwatch_lap_ctrl_lap_ram.sv - lap memory, one write port and one registered read port
module lap_ram #(
    parameter int DEPTH = 8,
    parameter int DW    = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    input  logic          i_rd_zero,
    input  logic [AW-1:0] i_rd_addr,
    output logic [DW-1:0] o_rd_data
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register only moves on a read, so the last word stays visible between reads.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= i_rd_zero ? '0 : r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - stopwatch run FSM, lap capture and lap-memory read arbiter
// Build option LAP_WRAP_EN: a lap taken while full overwrites the oldest entry.
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DW    = LAP_DW
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    stopwatch_lap_ctrl_if.slave  bus
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    state_t        r_state;
    logic          r_run_en;
    logic          r_timer_clr;
    logic          r_rd_ack;
    logic          r_ovf;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic          w_full;
    logic          w_lap;
    logic          w_wr;
    logic          w_rd_issue;
    logic          w_rd_zero;
    logic [AW-1:0] w_rd_addr;

    assign w_full = (r_count == FULL_CNT);
    assign w_lap  = bus.cmd_lap & ~bus.cmd_clear & ~bus.cmd_pause & ~bus.cmd_start
                  & (r_state == RUN);

`ifdef LAP_WRAP_EN
    assign w_wr = w_lap;
`else
    assign w_wr = w_lap & ~w_full;
`endif

    // Capture owns the memory port this cycle; a read waiting behind it issues next cycle.
    assign w_rd_issue = bus.rd_req & ~r_rd_ack & ~w_wr;
    assign w_rd_addr  = r_rd_ptr + bus.rd_idx;
    assign w_rd_zero  = ({1'b0, bus.rd_idx} >= r_count);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= IDLE;
            r_run_en    <= 1'b0;
            r_timer_clr <= 1'b0;
            r_rd_ack    <= 1'b0;
            r_ovf       <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
        end else begin
            r_timer_clr <= bus.cmd_clear;
            r_rd_ack    <= w_rd_issue;
            if (bus.cmd_clear) begin
                r_state  <= IDLE;
                r_run_en <= 1'b0;
                r_ovf    <= 1'b0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else if (bus.cmd_pause) begin
                if (r_state == RUN) begin
                    r_state  <= PAUSE;
                    r_run_en <= 1'b0;
                end
            end else if (bus.cmd_start) begin
                r_state  <= RUN;
                r_run_en <= 1'b1;
            end else if (w_lap) begin
                if (w_full) begin
                    r_ovf <= 1'b1;
                end
                if (w_wr) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    if (w_full) begin
                        r_rd_ptr <= r_rd_ptr + 1'b1;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
            end
        end
    end

    lap_ram #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_lap_ram (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_wr),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.time_bcd),
        .i_rd_en   (w_rd_issue),
        .i_rd_zero (w_rd_zero),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (bus.rd_data)
    );

    assign bus.run_en    = r_run_en;
    assign bus.timer_clr = r_timer_clr;
    assign bus.rd_ack    = r_rd_ack;
    assign bus.lap_count = r_count;
    assign bus.full      = w_full;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb/tb_stopwatch_lap_ctrl.sv - directed self-checking bench for stopwatch_lap_ctrl
module tb_stopwatch_lap_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 16;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    stopwatch_lap_ctrl_if #(.DEPTH(DEPTH), .DW(DW)) bus ();

    stopwatch_lap_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    task automatic lap(input logic [15:0] t);
        bus.time_bcd = t;
        bus.cmd_lap  = 1'b1;
        tick();
        bus.cmd_lap  = 1'b0;
    endtask

    // Host read: holds rd_req until rd_ack (bounded), then drops it.
    task automatic do_read(input logic [2:0] idx, output logic [15:0] data, output int lat);
        bus.rd_idx = idx;
        bus.rd_req = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat++;
            if (bus.rd_ack === 1'b1) break;
        end
        bus.rd_req = 1'b0;
        data = bus.rd_data;
        tick();
        check("ack_not_back_to_back", 32'(bus.rd_ack), 32'd0);
    endtask

    logic [15:0] d;
    int          lat;

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_pause = 1'b0;
        bus.cmd_lap   = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.time_bcd  = '0;
        bus.rd_req    = 1'b0;
        bus.rd_idx    = '0;
        tick();
        tick();
        check("rst_run_en",    32'(bus.run_en),    32'd0);
        check("rst_timer_clr", 32'(bus.timer_clr), 32'd0);
        check("rst_rd_ack",    32'(bus.rd_ack),    32'd0);
        check("rst_rd_data",   32'(bus.rd_data),   32'd0);
        check("rst_lap_count", 32'(bus.lap_count), 32'd0);
        check("rst_full",      32'(bus.full),      32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        rst_n = 1'b1;
        tick();

        // Lap in IDLE is ignored; start/pause timing.
        lap(16'h0001);
        check("idle_lap_ignored", 32'(bus.lap_count), 32'd0);
        pulse_start();
        check("run_en_after_start", 32'(bus.run_en), 32'd1);
        tick(); tick(); tick();
        check("run_en_held", 32'(bus.run_en), 32'd1);
        bus.cmd_pause = 1'b1;
        tick();
        bus.cmd_pause = 1'b0;
        check("run_en_after_pause", 32'(bus.run_en), 32'd0);
        lap(16'h1111);
        check("pause_lap_ignored", 32'(bus.lap_count), 32'd0);

        // Three laps and latency-1 reads.
        pulse_start();
        check("run_en_resume", 32'(bus.run_en), 32'd1);
        lap(16'h0012);
        check("count_1", 32'(bus.lap_count), 32'd1);
        lap(16'h0105);
        lap(16'h5959);
        check("count_3", 32'(bus.lap_count), 32'd3);
        do_read(3'd0, d, lat);
        check("rd0_data", 32'(d), 32'h0012);
        check("rd0_lat", 32'(lat), 32'd1);
        do_read(3'd1, d, lat);
        check("rd1_data", 32'(d), 32'h0105);
        check("rd1_lat", 32'(lat), 32'd1);
        do_read(3'd2, d, lat);
        check("rd2_data", 32'(d), 32'h5959);
        check("rd2_lat", 32'(lat), 32'd1);

        // Lap and read in the same cycle: write wins, read acks 2 cycles after request.
        bus.time_bcd = 16'h0230;
        bus.cmd_lap  = 1'b1;
        bus.rd_idx   = 3'd3;
        bus.rd_req   = 1'b1;
        tick();
        bus.cmd_lap  = 1'b0;
        check("coll_count", 32'(bus.lap_count), 32'd4);
        check("coll_no_ack_1", 32'(bus.rd_ack), 32'd0);
        tick();
        check("coll_ack_2", 32'(bus.rd_ack), 32'd1);
        check("coll_data", 32'(bus.rd_data), 32'h0230);
        bus.rd_req = 1'b0;
        tick();
        check("coll_ack_drop", 32'(bus.rd_ack), 32'd0);

        // Index beyond stored laps returns zero but still acks.
        do_read(3'd5, d, lat);
        check("oob_data", 32'(d), 32'h0000);
        check("oob_lat", 32'(lat), 32'd1);

        // Clear then DEPTH+1 laps.
        bus.cmd_clear = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
        check("clr_strobe", 32'(bus.timer_clr), 32'd1);
        check("clr_count", 32'(bus.lap_count), 32'd0);
        check("clr_run_en", 32'(bus.run_en), 32'd0);
        tick();
        check("clr_strobe_end", 32'(bus.timer_clr), 32'd0);
        pulse_start();
        for (int i = 1; i <= DEPTH; i++) lap(16'h0100 + 16'(i));
        check("fill_full", 32'(bus.full), 32'd1);
        check("fill_ovf", 32'(bus.ovf), 32'd0);
        lap(16'h0109);
        check("over_ovf", 32'(bus.ovf), 32'd1);
        check("over_count", 32'(bus.lap_count), 32'd8);
        do_read(3'd0, d, lat);
`ifdef LAP_WRAP_EN
        check("over_idx0", 32'(d), 32'h0102);
`else
        check("over_idx0", 32'(d), 32'h0101);
`endif
        do_read(3'd7, d, lat);
`ifdef LAP_WRAP_EN
        check("over_idx7", 32'(d), 32'h0109);
`else
        check("over_idx7", 32'(d), 32'h0108);
`endif

        // Pause beats start in the same cycle.
        bus.cmd_pause = 1'b1;
        bus.cmd_start = 1'b1;
        tick();
        bus.cmd_pause = 1'b0;
        bus.cmd_start = 1'b0;
        check("pause_over_start", 32'(bus.run_en), 32'd0);
        pulse_start();

        // Clear beats start and lap in the same cycle.
        bus.cmd_clear = 1'b1;
        bus.cmd_start = 1'b1;
        bus.cmd_lap   = 1'b1;
        tick();
        bus.cmd_clear = 1'b0;
        bus.cmd_start = 1'b0;
        bus.cmd_lap   = 1'b0;
        check("cs_run_en", 32'(bus.run_en), 32'd0);
        check("cs_strobe", 32'(bus.timer_clr), 32'd1);
        check("cs_count", 32'(bus.lap_count), 32'd0);
        check("cs_ovf", 32'(bus.ovf), 32'd0);
        check("cs_full", 32'(bus.full), 32'd0);

        // Reset while a read is pending.
        pulse_start();
        lap(16'h0042);
        check("pre_rst_count", 32'(bus.lap_count), 32'd1);
        bus.rd_idx = 3'd0;
        bus.rd_req = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_data", 32'(bus.rd_data), 32'h0000);
        check("mid_rst_run_en", 32'(bus.run_en), 32'd0);
        check("mid_rst_count", 32'(bus.lap_count), 32'd0);
        tick();
        check("mid_rst_rd_ack", 32'(bus.rd_ack), 32'd0);
        tick();
        check("mid_rst_rd_ack2", 32'(bus.rd_ack), 32'd0);
        bus.rd_req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_rd_ack", 32'(bus.rd_ack), 32'd0);
        check("post_rst_ovf", 32'(bus.ovf), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
